// File: rtl/scurve_sweep_control_if.sv
// scurve_sweep_control_if: control, config and FIFO signals of the S-curve sweep sequencer
interface scurve_sweep_control_if #(
    parameter int DAC_WIDTH = 10,
    parameter int CNT_WIDTH = 16
);
    logic                 SweepStart;
    logic                 SweepStop;
    logic [DAC_WIDTH-1:0] StartDAC;
    logic [DAC_WIDTH-1:0] EndDAC;
    logic [DAC_WIDTH-1:0] DACStep;
    logic                 AllChannelMode;
    logic [5:0]           StartChannel;
    logic [5:0]           EndChannel;
    logic [CNT_WIDTH-1:0] MaxCountNumber;
    logic                 CountClkEn;
    logic                 TriggerIn;
    logic                 MicrorocConfigDone;
    logic                 FifoFull;
    logic [DAC_WIDTH-1:0] OutDAC;
    logic [5:0]           OutChannel;
    logic                 ChannelMaskAll;
    logic                 LoadSCParameter;
    logic                 CountEnable;
    logic [CNT_WIDTH-1:0] ScurveData;
    logic                 ScurveData_en;
    logic                 OneDACDone;
    logic                 SweepDone;
    logic                 Busy;

    modport master (
        output SweepStart, SweepStop, StartDAC, EndDAC, DACStep, AllChannelMode,
               StartChannel, EndChannel, MaxCountNumber, CountClkEn, TriggerIn,
               MicrorocConfigDone, FifoFull,
        input  OutDAC, OutChannel, ChannelMaskAll, LoadSCParameter, CountEnable,
               ScurveData, ScurveData_en, OneDACDone, SweepDone, Busy
    );

    modport slave (
        input  SweepStart, SweepStop, StartDAC, EndDAC, DACStep, AllChannelMode,
               StartChannel, EndChannel, MaxCountNumber, CountClkEn, TriggerIn,
               MicrorocConfigDone, FifoFull,
        output OutDAC, OutChannel, ChannelMaskAll, LoadSCParameter, CountEnable,
               ScurveData, ScurveData_en, OneDACDone, SweepDone, Busy
    );
endinterface

// File: rtl/scurve_sweep_control.sv
// scurve_sweep_control: channel x DAC threshold scan, counts triggers per point and streams framed records to the readout FIFO
module scurve_sweep_control #(
    parameter int          DAC_WIDTH    = 10,
    parameter int          CNT_WIDTH    = 16,
    parameter logic [15:0] HEADER_WORD  = 16'h5343,
    parameter logic [15:0] TRAILER_WORD = 16'h5345
) (
    input logic                   Clk,
    input logic                   reset_n,
    scurve_sweep_control_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, HEADER, LOAD_SC, WAIT_CFG, COUNT, WR_POINT, WR_TRIG, WR_CLK, NEXT, TRAILER
    } state_t;

    state_t               r_state;
    logic [DAC_WIDTH-1:0] r_start_dac, r_end_dac, r_step, r_out_dac;
    logic [5:0]           r_end_ch, r_out_ch;
    logic [CNT_WIDTH-1:0] r_max, r_clk_cnt, r_trig, r_data;
    logic                 r_all, r_load_sc, r_count_en, r_data_en, r_one_done, r_done, r_busy;
    logic [DAC_WIDTH:0]   w_sum;
    logic                 w_last_dac, w_wr_state;
    logic [CNT_WIDTH-1:0] w_word;

    // 11-bit sum so a step past the top code ends the channel instead of wrapping
    assign w_sum      = {1'b0, r_out_dac} + {1'b0, r_step};
    assign w_last_dac = (r_out_dac >= r_end_dac) || (w_sum > {1'b0, r_end_dac});
    assign w_wr_state = (r_state == HEADER) || (r_state == WR_POINT) || (r_state == WR_TRIG) ||
                        (r_state == WR_CLK) || (r_state == TRAILER);
    assign w_word     = (r_state == HEADER)   ? CNT_WIDTH'(HEADER_WORD) :
                        (r_state == WR_POINT) ? CNT_WIDTH'({r_out_ch, r_out_dac}) :
                        (r_state == WR_TRIG)  ? r_trig :
                        (r_state == WR_CLK)   ? r_clk_cnt : CNT_WIDTH'(TRAILER_WORD);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_start_dac <= '0;
            r_end_dac   <= '0;
            r_step      <= '0;
            r_out_dac   <= '0;
            r_end_ch    <= '0;
            r_out_ch    <= '0;
            r_max       <= '0;
            r_clk_cnt   <= '0;
            r_trig      <= '0;
            r_data      <= '0;
            r_all       <= 1'b0;
            r_load_sc   <= 1'b0;
            r_count_en  <= 1'b0;
            r_data_en   <= 1'b0;
            r_one_done  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else if (r_state != IDLE && bus.SweepStop) begin
            r_state    <= IDLE;
            r_out_dac  <= '0;
            r_out_ch   <= '0;
            r_data     <= '0;
            r_all      <= 1'b0;
            r_load_sc  <= 1'b0;
            r_count_en <= 1'b0;
            r_data_en  <= 1'b0;
            r_one_done <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_load_sc  <= 1'b0;
            r_data_en  <= 1'b0;
            r_one_done <= 1'b0;
            if (w_wr_state && !bus.FifoFull) begin
                r_data    <= w_word;
                r_data_en <= 1'b1;
            end
            case (r_state)
                IDLE: if (bus.SweepStart) begin
                    r_start_dac <= bus.StartDAC;
                    r_end_dac   <= bus.EndDAC;
                    r_step      <= (bus.DACStep == '0) ? DAC_WIDTH'(1) : bus.DACStep;
                    r_end_ch    <= bus.EndChannel;
                    r_max       <= bus.MaxCountNumber;
                    r_all       <= bus.AllChannelMode;
                    r_out_dac   <= bus.StartDAC;
                    r_out_ch    <= bus.StartChannel;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b1;
                    r_state     <= HEADER;
                end
                HEADER: if (!bus.FifoFull) begin
                    r_load_sc <= 1'b1;
                    r_state   <= LOAD_SC;
                end
                LOAD_SC: r_state <= WAIT_CFG;
                WAIT_CFG: if (bus.MicrorocConfigDone) begin
                    r_clk_cnt  <= '0;
                    r_trig     <= '0;
                    r_count_en <= 1'b1;
                    r_state    <= COUNT;
                end
                COUNT: if (r_clk_cnt == r_max) begin
                    r_count_en <= 1'b0;
                    r_state    <= WR_POINT;
                end else begin
                    if (bus.CountClkEn) r_clk_cnt <= r_clk_cnt + CNT_WIDTH'(1);
                    if (bus.TriggerIn && r_trig != '1) r_trig <= r_trig + CNT_WIDTH'(1);
                    // the closing strobe ends the window in the same cycle it is counted
                    if (bus.CountClkEn && (r_clk_cnt + CNT_WIDTH'(1)) == r_max) begin
                        r_count_en <= 1'b0;
                        r_state    <= WR_POINT;
                    end
                end
                WR_POINT: if (!bus.FifoFull) r_state <= WR_TRIG;
                WR_TRIG:  if (!bus.FifoFull) r_state <= WR_CLK;
                WR_CLK: if (!bus.FifoFull) begin
                    r_one_done <= 1'b1;
                    r_state    <= NEXT;
                end
                NEXT: if (w_last_dac && (r_all || r_out_ch >= r_end_ch)) begin
                    r_state <= TRAILER;
                end else begin
                    r_out_ch  <= w_last_dac ? r_out_ch + 6'd1 : r_out_ch;
                    r_out_dac <= w_last_dac ? r_start_dac : w_sum[DAC_WIDTH-1:0];
                    r_load_sc <= 1'b1;
                    r_state   <= LOAD_SC;
                end
                TRAILER: if (!bus.FifoFull) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.OutDAC          = r_out_dac;
    assign bus.OutChannel      = r_out_ch;
    assign bus.ChannelMaskAll  = r_all;
    assign bus.LoadSCParameter = r_load_sc;
    assign bus.CountEnable     = r_count_en;
    assign bus.ScurveData      = r_data;
    assign bus.ScurveData_en   = r_data_en;
    assign bus.OneDACDone      = r_one_done;
    assign bus.SweepDone       = r_done;
    assign bus.Busy            = r_busy;
endmodule

// File: tb/tb_scurve_sweep_control.sv
// tb_scurve_sweep_control: table of sweeps checked through an expected-word queue, plus stall/abort/reset sequences
module tb_scurve_sweep_control;
    logic Clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 Clk = ~Clk;

    scurve_sweep_control_if bus ();
    scurve_sweep_control dut (.Clk(Clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        int sd, ed, step;
        bit all;
        int sc, ec, mx, ntrig;
        bit force_t;
        int pts;
    } vec_t;

    vec_t        vecs[6];
    logic [15:0] exp_q[$];
    int          total = 0, bad = 0;
    int          load_cnt = 0, done_cnt = 0;
    int          ntrig = 0, issued = 0, cyc = 0, cfg_cnt = 0;
    bit          force_trig = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic sig(input int sel);
        return (sel == 0) ? bus.CountEnable : (sel == 1) ? bus.ScurveData_en : bus.SweepDone;
    endfunction

    function automatic logic outs_nonzero();
        return |{bus.OutDAC, bus.OutChannel, bus.ChannelMaskAll, bus.LoadSCParameter, bus.CountEnable,
                 bus.ScurveData, bus.ScurveData_en, bus.OneDACDone, bus.SweepDone, bus.Busy};
    endfunction

    // reference strobe every 4 cycles, triggers issued while the window is open, config done 2 cycles after load
    initial begin
        bus.CountClkEn = 1'b0;
        bus.TriggerIn = 1'b0;
        bus.MicrorocConfigDone = 1'b0;
        forever begin
            @(negedge Clk);
            cyc++;
            bus.CountClkEn = (cyc % 4 == 0);
            if (!bus.CountEnable) issued = 0;
            bus.TriggerIn = force_trig || (bus.CountEnable && issued < ntrig);
            if (bus.CountEnable && issued < ntrig) issued++;
            if (bus.LoadSCParameter) cfg_cnt = 3;
            else if (cfg_cnt > 0) cfg_cnt--;
            bus.MicrorocConfigDone = (cfg_cnt == 1);
        end
    end

    always @(negedge Clk) begin
        if (bus.LoadSCParameter) load_cnt++;
        if (bus.OneDACDone) done_cnt++;
        if (bus.ScurveData_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word: got %0h want none", bus.ScurveData);
            end else check("fifo_word", bus.ScurveData, exp_q.pop_front());
        end
    end

    function automatic void build_expect(input vec_t v, input int keep);
        int st, ch, dac, tw;
        st = (v.step == 0) ? 1 : v.step;
        tw = v.force_t ? 0 : (v.ntrig > 65535 ? 65535 : v.ntrig);
        ch = v.sc;
        exp_q.push_back(16'h5343);
        forever begin
            dac = v.sd;
            forever begin
                exp_q.push_back({ch[5:0], dac[9:0]});
                exp_q.push_back(tw[15:0]);
                exp_q.push_back(v.mx[15:0]);
                if (dac >= v.ed || dac + st > v.ed) break;
                dac += st;
            end
            if (v.all || ch >= v.ec) break;
            ch++;
        end
        exp_q.push_back(16'h5345);
        if (keep >= 0) while (exp_q.size() > keep) void'(exp_q.pop_back());
    endfunction

    task automatic start_sweep(input vec_t v, input int keep);
        build_expect(v, keep);
        @(negedge Clk);
        load_cnt = 0;
        done_cnt = 0;
        ntrig = v.ntrig;
        force_trig = v.force_t;
        bus.StartDAC = v.sd[9:0];
        bus.EndDAC = v.ed[9:0];
        bus.DACStep = v.step[9:0];
        bus.AllChannelMode = v.all;
        bus.StartChannel = v.sc[5:0];
        bus.EndChannel = v.ec[5:0];
        bus.MaxCountNumber = v.mx[15:0];
        bus.SweepStart = 1'b1;
        @(negedge Clk);
        bus.SweepStart = 1'b0;
        check("done_clear", bus.SweepDone, 0);
        check("busy_set", bus.Busy, 1);
        repeat (6) @(negedge Clk);
        bus.StartDAC = 10'($urandom);
        bus.EndDAC = 10'($urandom);
        bus.DACStep = 10'($urandom);
        bus.StartChannel = 6'($urandom);
        bus.EndChannel = 6'($urandom);
        bus.MaxCountNumber = 16'($urandom_range(1, 50));
        bus.AllChannelMode = ~v.all;
        bus.SweepStart = 1'b1;
        @(negedge Clk);
        bus.SweepStart = 1'b0;
    endtask

    task automatic wait_sig(input int sel, input logic val, input string name);
        int n = 0;
        while (sig(sel) !== val && n < 90000) begin
            @(negedge Clk);
            n++;
        end
        check(name, sig(sel) === val, 1);
    endtask

    task automatic wait_done(input int pts);
        wait_sig(2, 1'b1, "done_wait");
        @(negedge Clk);
        check("load_pulses", load_cnt, pts);
        check("point_pulses", done_cnt, pts);
        check("words_left", exp_q.size(), 0);
        check("busy_end", bus.Busy, 0);
        check("done_level", bus.SweepDone, 1);
    endtask

    initial begin
        logic [15:0] held;
        bit stall_ok;
        vecs[0] = '{500, 505, 1, 1'b0, 5, 5, 10, 3, 1'b0, 6};
        vecs[1] = '{0, 20, 10, 1'b0, 0, 2, 4, 2, 1'b0, 9};
        vecs[2] = '{800, 700, 1, 1'b0, 3, 3, 0, 0, 1'b1, 1};
        vecs[3] = '{1000, 1023, 1023, 1'b0, 1, 1, 18000, 70000, 1'b0, 1};
        vecs[4] = '{1020, 1023, 0, 1'b1, 2, 9, 5, 4, 1'b0, 4};
        vecs[5] = '{10, 12, 2, 1'b0, 7, 3, 3, 1, 1'b0, 2};
        bus.SweepStart = 1'b0;
        bus.SweepStop = 1'b0;
        bus.StartDAC = '0;
        bus.EndDAC = '0;
        bus.DACStep = '0;
        bus.AllChannelMode = 1'b0;
        bus.StartChannel = '0;
        bus.EndChannel = '0;
        bus.MaxCountNumber = '0;
        bus.FifoFull = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_outputs", outs_nonzero(), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            start_sweep(vecs[i], -1);
            if (i == 4) check("mask_all", bus.ChannelMaskAll, 1);
            wait_done(vecs[i].pts);
            force_trig = 1'b0;
        end

        start_sweep(vecs[0], -1);
        wait_sig(0, 1'b1, "cnt_open");
        wait_sig(0, 1'b0, "cnt_close");
        wait_sig(1, 1'b1, "point_write");
        bus.FifoFull = 1'b1;
        held = bus.ScurveData;
        stall_ok = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (bus.ScurveData_en || bus.ScurveData != held) stall_ok = 1'b0;
        end
        check("stall_hold", stall_ok, 1);
        bus.FifoFull = 1'b0;
        wait_done(6);

        start_sweep(vecs[0], 1);
        wait_sig(0, 1'b1, "abort_cnt");
        bus.SweepStop = 1'b1;
        @(negedge Clk);
        bus.SweepStop = 1'b0;
        check("abort_outputs", outs_nonzero(), 0);
        repeat (10) @(negedge Clk);
        check("abort_words", exp_q.size(), 0);
        check("abort_done", bus.SweepDone, 0);

        start_sweep(vecs[0], 2);
        wait_sig(0, 1'b0, "rst_cnt_close");
        wait_sig(1, 1'b1, "rst_point");
        reset_n = 1'b0;
        #1;
        check("reset_outputs_mid", outs_nonzero(), 0);
        @(negedge Clk);
        reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        check("reset_words", exp_q.size(), 0);

        start_sweep(vecs[0], -1);
        wait_done(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scurve_sweep_control.md
Name: scurve_sweep_control

Overview:
Sequences a threshold-DAC S-curve scan on a MICROROC. The scan loops over channels (outer) and DAC codes (inner). For each point the block loads the slow-control parameters, waits for the config handshake, counts triggers over a fixed window of reference-clock strobes, then writes a 3-word result record into the downstream USB/readout FIFO. Header and trailer words frame each sweep.

Parameters:
DAC_WIDTH, 10, width of the DAC code fields
CNT_WIDTH, 16, width of the window and trigger counters
HEADER_WORD, 16'h5343, first word written for each sweep
TRAILER_WORD, 16'h5345, last word written for a normally completed sweep

Ports:
Clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
SweepStart  input  1  one-cycle start pulse; honoured only in IDLE
SweepStop  input  1  abort request; honoured in any non-IDLE state
StartDAC  input  10  first DAC code
EndDAC  input  10  last DAC code (inclusive bound)
DACStep  input  10  DAC increment; 0 is treated as 1
AllChannelMode  input  1  1 = single pass with all channels enabled
StartChannel  input  6  first channel
EndChannel  input  6  last channel
MaxCountNumber  input  16  window length in CountClkEn strobes
CountClkEn  input  1  reference strobe, one cycle wide
TriggerIn  input  1  synchronous trigger pulse, one cycle wide
MicrorocConfigDone  input  1  slow-control load complete
FifoFull  input  1  downstream FIFO full
OutDAC  output  10  DAC code under test
OutChannel  output  6  channel under test
ChannelMaskAll  output  1  copy of AllChannelMode, latched at start
LoadSCParameter  output  1  one-cycle SC load request
CountEnable  output  1  high while the count window is open
ScurveData  output  16  FIFO write data
ScurveData_en  output  1  FIFO write strobe
OneDACDone  output  1  one-cycle pulse after each point's record is written
SweepDone  output  1  level; high from trailer write until next SweepStart
Busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-sweep aborts immediately with no trailer.
- Configuration latch: StartDAC, EndDAC, DACStep, StartChannel, EndChannel, MaxCountNumber and AllChannelMode are latched on the accepted SweepStart. Later input changes are ignored until the next sweep.
- FSM states: IDLE, HEADER, LOAD_SC, WAIT_CFG, COUNT, WR_POINT, WR_TRIG, WR_CLK, NEXT, TRAILER.
  - IDLE -> HEADER on SweepStart. SweepDone clears in the same cycle.
  - HEADER: write HEADER_WORD -> LOAD_SC.
  - LOAD_SC: LoadSCParameter = 1 for exactly one cycle -> WAIT_CFG. OutDAC and OutChannel are valid in LOAD_SC and stay stable until NEXT.
  - WAIT_CFG: wait for MicrorocConfigDone = 1; no timeout. Both counters clear on exit -> COUNT.
  - COUNT: CountEnable = 1.
    - Each CountClkEn increments ClkCount.
    - Each TriggerIn increments TrigCount, saturating at 16'hFFFF.
    - Leave when ClkCount reaches MaxCountNumber. MaxCountNumber = 0 closes the window immediately and both counts are 0.
    - A TriggerIn coincident with the final CountClkEn is counted.
    - TriggerIn outside COUNT is ignored.
  - WR_POINT: write {OutChannel, OutDAC}.
  - WR_TRIG: write TrigCount.
  - WR_CLK: write ClkCount.
  - NEXT: OneDACDone = 1 for one cycle. Compute the 11-bit sum OutDAC + step:
    - If OutDAC >= EndDAC or sum > EndDAC, the channel is finished.
    - Otherwise OutDAC takes the sum -> LOAD_SC.
  - Channel finished:
    - If AllChannelMode = 1 or OutChannel >= EndChannel -> TRAILER.
    - Otherwise OutChannel increments, OutDAC reloads StartDAC -> LOAD_SC.
  - TRAILER: write TRAILER_WORD, set SweepDone -> IDLE.
- FIFO write rule:
  - Any write state asserts ScurveData_en for one cycle only when FifoFull = 0, then advances.
  - While FifoFull = 1 the FSM holds, ScurveData_en = 0, ScurveData holds its value and the counters are frozen.
  - Writes are back-to-back when the FIFO is not full.
- Boundaries:
  - StartDAC > EndDAC gives one point at StartDAC.
  - StartChannel > EndChannel gives one channel pass.
  - DAC sum overflow past 1023 ends the channel.
- Abort: SweepStop in any non-IDLE state goes to IDLE on the next cycle. All strobes drop, no trailer is written, SweepDone stays 0. An abort during WAIT_CFG leaves the SC load incomplete; the next sweep reloads.
- Start while Busy: SweepStart is ignored.

Test Plan:
- Single channel, DAC 500..505, step 1, MaxCount 10, 3 triggers per window -> 6 LoadSC pulses, 6 OneDACDone pulses, 20 FIFO words. Each point's trigger word is 3 and clock word is 10; record sequence is 5343, then {ch,500},3,10 through {ch,505},3,10, then 5345.
- Channels 0..2, DAC 0..20, step 10 -> points per channel are DAC 0, 10, 20. Channel increments after DAC 20, DAC reloads to 0, 9 points total, SweepDone high after the trailer.
- FifoFull held high for 20 cycles during WR_TRIG -> no writes, FSM holds with value stable, then the remaining words are written in order with no loss or duplication.
- MaxCountNumber 0 and StartDAC 800 > EndDAC 700 -> exactly one point at 800 with trigger word 0 and clock word 0. TriggerIn pulses before COUNT are not counted.
- 70000 triggers in the window with step 1023 from DAC 1000 -> trigger word saturates at FFFF. The next DAC sum overflows, so the channel ends after one point.
- SweepStop asserted in COUNT, and separately reset_n pulled low mid-write -> both return to IDLE with all outputs 0, no trailer, SweepDone 0. A following SweepStart runs a clean sweep beginning with header 5343.
